// File: rtl/pwm_pkg.sv
// Shared types and helpers for the complementary PWM dead-time inserter.
package pwm_pkg;

  localparam int unsigned DT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_DT  = 2'd1,
    ST_HI  = 2'd2,
    ST_LO  = 2'd3
  } pwm_state_e;

  // A zero dead time still yields one both-off cycle, so the load value is max(dt,1)-1.
  function automatic int unsigned dt_load_val(input int unsigned dt);
    return (dt == 0) ? 0 : dt - 1;
  endfunction

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter with a zero flag, used to time the both-off interval.
module pwm_dt_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Converts one PWM waveform into a high/low gate-drive pair with dead time,
// short-pulse absorption and a latched fault shutdown.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault,
  input  logic                fault_clr,
  output logic                pwm_hi,
  output logic                pwm_lo,
  output logic                in_deadtime,
  output logic                fault_latched
);

  pwm_state_e          r_state;
  logic                r_hi;
  logic                r_lo;
  logic                r_dt;
  logic                r_fault;
  logic                w_norm;
  logic                w_load;
  logic                w_dec;
  logic                w_zero;
  logic [DT_WIDTH-1:0] w_load_val;

  // Normal transitions only happen when no fault is pending or latched and the block is enabled.
  assign w_norm     = !fault && !r_fault && enable;
  assign w_load     = w_norm && ((r_state == ST_OFF) ||
                                 (r_state == ST_HI && !pwm_in) ||
                                 (r_state == ST_LO &&  pwm_in));
  assign w_dec      = w_norm && (r_state == ST_DT) && !w_zero;
  assign w_load_val = DT_WIDTH'(dt_load_val(32'(dead_time)));

  pwm_dt_counter #(.W(DT_WIDTH)) u_cnt (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_OFF;
      r_hi    <= 1'b0;
      r_lo    <= 1'b0;
      r_dt    <= 1'b0;
      r_fault <= 1'b0;
    end else if (fault) begin
      r_state <= ST_OFF;
      r_hi    <= 1'b0;
      r_lo    <= 1'b0;
      r_dt    <= 1'b0;
      r_fault <= 1'b1;
    end else if (r_fault) begin
      // Clearing only releases the latch; restart goes through OFF on a later edge.
      r_state <= ST_OFF;
      r_hi    <= 1'b0;
      r_lo    <= 1'b0;
      r_dt    <= 1'b0;
      if (fault_clr) r_fault <= 1'b0;
    end else if (!enable) begin
      r_state <= ST_OFF;
      r_hi    <= 1'b0;
      r_lo    <= 1'b0;
      r_dt    <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_state <= ST_DT;
          r_dt    <= 1'b1;
        end
        ST_DT: begin
          // Side is picked at expiry, so pulses shorter than the interval vanish.
          if (w_zero) begin
            r_dt <= 1'b0;
            if (pwm_in) begin
              r_state <= ST_HI;
              r_hi    <= 1'b1;
            end else begin
              r_state <= ST_LO;
              r_lo    <= 1'b1;
            end
          end
        end
        ST_HI: begin
          if (!pwm_in) begin
            r_state <= ST_DT;
            r_hi    <= 1'b0;
            r_dt    <= 1'b1;
          end
        end
        ST_LO: begin
          if (pwm_in) begin
            r_state <= ST_DT;
            r_lo    <= 1'b0;
            r_dt    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_hi    <= 1'b0;
          r_lo    <= 1'b0;
          r_dt    <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_hi        = r_hi;
  assign pwm_lo        = r_lo;
  assign in_deadtime   = r_dt;
  assign fault_latched = r_fault;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed, table-driven bench for pwm_deadtime with hand-written async-reset sequences.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_in = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] dead_time = 8'd0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       pwm_hi, pwm_lo, in_deadtime, fault_latched;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       pwm;
    logic       en;
    logic [7:0] dt;
    logic       f;
    logic       fc;
    logic [3:0] exp; // {pwm_hi, pwm_lo, in_deadtime, fault_latched}
  } vec_t;

  vec_t vq[$];

  pwm_deadtime dut (
    .clk           (clk),
    .reset         (reset),
    .pwm_in        (pwm_in),
    .enable        (enable),
    .dead_time     (dead_time),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .pwm_hi        (pwm_hi),
    .pwm_lo        (pwm_lo),
    .in_deadtime   (in_deadtime),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] OFF = 4'b0000, DT = 4'b0010, HI = 4'b1000,
                         LO = 4'b0100, FL = 4'b0001;

  task automatic add(input logic p, input logic e, input logic [7:0] d,
                     input logic f, input logic fc, input logic [3:0] x);
    vec_t v;
    v.pwm = p; v.en = e; v.dt = d; v.f = f; v.fc = fc; v.exp = x;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {pwm_hi, pwm_lo, in_deadtime, fault_latched};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: hi/lo/dt/fl got %b required %b at %0t", name, got, exp, $time);
    end
    tests++;
    if (pwm_hi && pwm_lo) begin
      fails++;
      $display("FAIL %s overlap: hi=%b lo=%b required not both 1", name, pwm_hi, pwm_lo);
    end
  endtask

  task automatic step(input logic p, input logic e, input logic [7:0] d,
                      input logic f, input logic fc);
    pwm_in = p; enable = e; dead_time = d; fault = f; fault_clr = fc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // start-up: enable with dt=4, pwm_hi on the 5th edge
    add(1,1,4,0,0,DT); add(1,1,4,0,0,DT); add(1,1,4,0,0,DT); add(1,1,4,0,0,DT);
    add(1,1,4,0,0,HI); add(1,1,4,0,0,HI);
    // falling edge with dt=3
    add(0,1,3,0,0,DT); add(0,1,3,0,0,DT); add(0,1,3,0,0,DT); add(0,1,3,0,0,LO);
    add(0,1,3,0,0,LO);
    // 2-cycle pulse absorbed by dt=6
    add(1,1,6,0,0,DT); add(1,1,6,0,0,DT); add(0,1,6,0,0,DT); add(0,1,6,0,0,DT);
    add(0,1,6,0,0,DT); add(0,1,6,0,0,DT); add(0,1,6,0,0,LO); add(0,1,6,0,0,LO);
    // dt=0 acts as dt=1, then dt=1
    add(1,1,0,0,0,DT); add(1,1,0,0,0,HI); add(0,1,0,0,0,DT); add(0,1,0,0,0,LO);
    add(1,1,1,0,0,DT); add(1,1,1,0,0,HI);
    // dead_time changed mid-interval only affects the next interval
    add(0,1,3,0,0,DT); add(0,1,7,0,0,DT); add(0,1,7,0,0,DT); add(0,1,7,0,0,LO);
    add(1,1,1,0,0,DT); add(1,1,1,0,0,HI);
    // fault in HI, clear ignored while fault=1, then recovery through DT
    add(1,1,1,1,0,FL); add(1,1,1,1,1,FL); add(1,1,1,0,0,FL); add(1,1,1,0,1,OFF);
    add(1,1,2,0,0,DT); add(1,1,2,0,0,DT); add(1,1,2,0,0,HI);
    // enable drop and restart
    add(1,0,2,0,0,OFF); add(1,0,2,0,0,OFF); add(0,1,2,0,0,DT); add(0,1,2,0,0,DT);
    add(0,1,2,0,0,LO);
    // fault during DT
    add(1,1,2,0,0,DT); add(1,1,2,1,0,FL); add(1,1,2,0,1,OFF); add(1,1,2,0,0,DT);

    #2;
    chk("reset_state", OFF);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held", OFF);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].pwm, vq[i].en, vq[i].dt, vq[i].f, vq[i].fc);
      chk($sformatf("row%0d", i), vq[i].exp);
    end

    // reach DT with counter loaded to 5, then async reset between edges
    step(0,1,6,0,0); chk("pre_a", DT);
    step(0,1,6,0,0); chk("pre_b", LO);
    step(1,1,6,0,0); chk("dt_cnt5", DT);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_mid_dt", OFF);
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step(1,1,6,0,0);
      chk($sformatf("restart_edge%0d", i), (i == 7) ? HI : DT);
    end

    // async reset while driving high
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_in_hi", OFF);
    #2;
    reset = 1'b0;
    step(0,1,2,0,0); chk("post_rst_off_dt", DT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
